// File: rtl/iobuf_bank_reg_pkg.sv
// Shared definitions for the registered bidirectional I/O bank.
//   iob_state_e : direction FSM encoding (RX, TURN_TX, TX, TURN_RX)
//   cnt_width   : counter width able to hold 0..n-1 (minimum one bit)
package iobuf_bank_reg_pkg;

    typedef enum logic [1:0] {
        IobRx     = 2'd0,
        IobTurnTx = 2'd1,
        IobTx     = 2'd2,
        IobTurnRx = 2'd3
    } iob_state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/iobuf_bank_reg_if.sv
// Core-side bus of the I/O bank.
//   I       : data to drive onto the pads while transmitting
//   T       : direction request, 0 = transmit, 1 = receive
//   O       : captured pad data (last sync stage)
//   O_VALID : O holds data sampled entirely while receiving
//   TX_ACT  : pads currently driven
//   BUSY    : direction turnaround in progress
// master = core logic, slave = the I/O bank.
interface iobuf_bank_reg_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] I;
    logic             T;
    logic [WIDTH-1:0] O;
    logic             O_VALID;
    logic             TX_ACT;
    logic             BUSY;

    modport master (
        output I, T,
        input  O, O_VALID, TX_ACT, BUSY
    );

    modport slave (
        input  I, T,
        output O, O_VALID, TX_ACT, BUSY
    );
endinterface

// File: rtl/iobuf_bank_reg_bit.sv
// One pad channel of the I/O bank.
//   C  : clock, rising edge
//   R  : synchronous reset, active-high
//   D  : data to drive; registered on every edge
//   EN : registered drive enable from the bank FSM
//   IO : pad
//   Q  : last stage of the pad capture chain
module iobuf_bank_reg_bit #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        INIT_Q      = 1'b0
) (
    input  logic C,
    input  logic R,
    input  logic D,
    input  logic EN,
    inout  wire  IO,
    output logic Q
);

    logic                   data_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   tri_n;

    always_ff @(posedge C) begin
        if (R) begin
            data_q                 <= 1'b0;
            sync_q                 <= '0;
            sync_q[SYNC_STAGES-1]  <= INIT_Q;
        end else begin
            data_q    <= D;
            sync_q[0] <= IO;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // Active-low tristate control: pad is released whenever EN is low.
    assign tri_n = ~EN;
    bufif0 u_drv (IO, data_q, tri_n);

    assign Q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/iobuf_bank_reg.sv
// Registered bidirectional I/O bank with enforced bus turnaround.
//   C   : clock, rising edge
//   R   : synchronous reset, active-high
//   IO  : WIDTH pads
//   bus : core-side interface (I, T in; O, O_VALID, TX_ACT, BUSY out)
// Every direction change inserts TURN_CYCLES high-Z BUSY cycles. Pad data is
// captured through SYNC_STAGES flops; O_VALID marks samples taken wholly in RX.
module iobuf_bank_reg
    import iobuf_bank_reg_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      TURN_CYCLES = 2,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] INIT_O      = '0
) (
    input  logic                C,
    input  logic                R,
    inout  wire  [WIDTH-1:0]    IO,
    iobuf_bank_reg_if.slave     bus
);

    localparam int unsigned CntW = cnt_width(TURN_CYCLES);
    localparam int unsigned RunW = cnt_width(SYNC_STAGES + 1);
    localparam logic [CntW-1:0] TurnLoad = CntW'(TURN_CYCLES - 1);
    localparam logic [RunW-1:0] RunFull  = RunW'(SYNC_STAGES);

    iob_state_e       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [RunW-1:0]  rx_run_q, rx_run_d;
    logic             en_q;
    logic             busy_q;
    logic             valid_q;
    logic [WIDTH-1:0] cap;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IobRx: begin
                if (!bus.T) begin
                    state_d = IobTurnTx;
                    cnt_d   = TurnLoad;
                end
            end
            IobTurnTx: begin
                if (cnt_q == '0) state_d = IobTx;
                else             cnt_d   = cnt_q - 1'b1;
            end
            IobTx: begin
                if (bus.T) begin
                    state_d = IobTurnRx;
                    cnt_d   = TurnLoad;
                end
            end
            IobTurnRx: begin
                if (cnt_q == '0) state_d = IobRx;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: ;
        endcase

        // Count consecutive edges spent in RX, saturating once the capture
        // chain holds only receive-side samples.
        rx_run_d = '0;
        if (state_q == IobRx && state_d == IobRx) begin
            rx_run_d = (rx_run_q == RunFull) ? rx_run_q : rx_run_q + 1'b1;
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge C) begin
        if (R) begin
            state_q  <= IobRx;
            cnt_q    <= '0;
            rx_run_q <= '0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rx_run_q <= rx_run_d;
            en_q     <= (state_d == IobTx);
            busy_q   <= (state_d == IobTurnTx) || (state_d == IobTurnRx);
            valid_q  <= (state_d == IobRx) && (rx_run_d == RunFull);
        end
    end

    for (genvar n = 0; n < WIDTH; n++) begin : g_bit
        iobuf_bank_reg_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .INIT_Q      (INIT_O[n])
        ) u_bit (
            .C  (C),
            .R  (R),
            .D  (bus.I[n]),
            .EN (en_q),
            .IO (IO[n]),
            .Q  (cap[n])
        );
    end

    assign bus.O       = cap;
    assign bus.O_VALID = valid_q;
    assign bus.TX_ACT  = en_q;
    assign bus.BUSY    = busy_q;

endmodule

// File: tb/tb_iobuf_bank_reg.sv
// Directed bench for iobuf_bank_reg (WIDTH=8, TURN_CYCLES=2, SYNC_STAGES=2).
// Expectations are queued with the edge they are due on and checked 1ns after
// that edge. Whenever the DUT should be high-Z, the bench drives a probe value
// on the pads and expects to read it back unchanged.
module tb_iobuf_bank_reg;

    localparam int KO    = 0;
    localparam int KVal  = 1;
    localparam int KAct  = 2;
    localparam int KBusy = 3;
    localparam int KIo   = 4;

    typedef struct {
        int         cyc;
        int         kind;
        string      tag;
        logic [7:0] val;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] drv_val;
    logic       drv_en;
    wire  [7:0] pad;

    exp_t sb[$];
    int   edge_n;
    int   n_chk;
    int   n_pass;
    int   b, k, r, g;

    iobuf_bank_reg_if #(.WIDTH(8)) bus ();

    iobuf_bank_reg #(
        .WIDTH       (8),
        .TURN_CYCLES (2),
        .SYNC_STAGES (2),
        .INIT_O      (8'h00)
    ) dut (
        .C   (clk),
        .R   (rst),
        .IO  (pad),
        .bus (bus)
    );

    assign pad = drv_en ? drv_val : 8'hzz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic push(input int cyc, input int kind, input string tag,
                        input logic [7:0] val);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.tag  = tag;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic compare(input exp_t e);
        logic [7:0] obs;
        case (e.kind)
            KO:      obs = bus.O;
            KVal:    obs = {7'd0, bus.O_VALID};
            KAct:    obs = {7'd0, bus.TX_ACT};
            KBusy:   obs = {7'd0, bus.BUSY};
            default: obs = pad;
        endcase
        n_chk++;
        assert (obs === e.val) n_pass++;
        else $error("FAIL %s @edge %0d: got %h, want %h", e.tag, edge_n, obs, e.val);
    endtask

    task automatic drain();
        exp_t keep[$];
        foreach (sb[i]) begin
            if (sb[i].cyc <= edge_n) compare(sb[i]);
            else                     keep.push_back(sb[i]);
        end
        sb = keep;
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        #1;
        drain();
    endtask

    initial begin
        logic [7:0] steps [3];
        steps[0] = 8'h01;
        steps[1] = 8'h02;
        steps[2] = 8'h03;
        edge_n = 0;
        n_chk  = 0;
        n_pass = 0;

        // Reset with T asking to transmit and the bench holding the pads.
        rst = 1'b1; bus.T = 1'b0; bus.I = 8'hFF; drv_val = 8'h00; drv_en = 1'b1;
        push(2, KO,    "rst_o",     8'h00);
        push(2, KVal,  "rst_valid", 8'h00);
        push(2, KAct,  "rst_txact", 8'h00);
        push(2, KBusy, "rst_busy",  8'h00);
        push(2, KIo,   "rst_io",    8'h00);
        tick(); tick();

        // Receive capture: two-edge latency, valid after two RX edges.
        rst = 1'b0; bus.T = 1'b1; drv_val = 8'hA5;
        b = edge_n;
        push(b + 1, KO,    "rx_o_lat",   8'h00);
        push(b + 1, KVal,  "rx_valid1",  8'h00);
        push(b + 1, KIo,   "rx_io",      8'hA5);
        push(b + 2, KO,    "rx_o",       8'hA5);
        push(b + 2, KVal,  "rx_valid2",  8'h01);
        push(b + 2, KBusy, "rx_busy",    8'h00);
        push(b + 2, KAct,  "rx_txact",   8'h00);
        push(b + 3, KO,    "rx_o_hold",  8'hA5);
        tick(); tick(); tick();

        // RX -> TX turnaround.
        k = edge_n;
        bus.T = 1'b0; bus.I = 8'h3C;
        push(k + 1, KBusy, "ttx_busy1",  8'h01);
        push(k + 1, KVal,  "ttx_valid",  8'h00);
        push(k + 1, KAct,  "ttx_act1",   8'h00);
        push(k + 1, KIo,   "ttx_io1",    8'hA5);
        push(k + 2, KBusy, "ttx_busy2",  8'h01);
        push(k + 2, KAct,  "ttx_act2",   8'h00);
        push(k + 2, KIo,   "ttx_io2",    8'hA5);
        tick(); tick();
        drv_en = 1'b0;
        push(k + 3, KBusy, "tx_busy",    8'h00);
        push(k + 3, KAct,  "tx_act",     8'h01);
        push(k + 3, KIo,   "tx_io",      8'h3C);
        push(k + 5, KO,    "tx_loop_o",  8'h3C);
        push(k + 5, KVal,  "tx_valid",   8'h00);
        tick(); tick(); tick();

        // Drive latency: pads follow I one edge later.
        bus.I = steps[0];
        push(edge_n, KIo, "lat_pre", 8'h3C);
        #1;
        drain();
        foreach (steps[i]) begin
            bus.I = steps[i];
            push(edge_n + 1, KIo,   "lat_io",   steps[i]);
            push(edge_n + 1, KAct,  "lat_act",  8'h01);
            push(edge_n + 1, KBusy, "lat_busy", 8'h00);
            tick();
        end

        // Reset while transmitting releases the pads on the reset edge.
        bus.I = 8'h3C;
        push(edge_n + 1, KIo, "mid_pre_io", 8'h3C);
        tick();
        rst = 1'b1;
        r = edge_n + 1;
        push(r, KAct,  "mid_act",   8'h00);
        push(r, KBusy, "mid_busy",  8'h00);
        push(r, KO,    "mid_o",     8'h00);
        push(r, KVal,  "mid_valid", 8'h00);
        tick();
        drv_val = 8'h96; drv_en = 1'b1;
        push(edge_n, KIo, "mid_io_rel", 8'h96);
        #1;
        drain();
        rst = 1'b0; bus.T = 1'b1;
        push(edge_n + 1, KBusy, "post_busy", 8'h00);
        push(edge_n + 1, KAct,  "post_act",  8'h00);
        push(edge_n + 2, KO,    "post_o",    8'h96);
        push(edge_n + 2, KVal,  "post_val",  8'h01);
        tick(); tick();

        // One-cycle T glitch: both turnarounds still run to completion.
        g = edge_n;
        drv_val = 8'h5A; bus.T = 1'b0; bus.I = 8'hC3;
        push(g + 1, KBusy, "gl_busy1", 8'h01);
        push(g + 1, KAct,  "gl_act1",  8'h00);
        push(g + 1, KVal,  "gl_val1",  8'h00);
        push(g + 1, KIo,   "gl_io1",   8'h5A);
        tick();
        bus.T = 1'b1;
        push(g + 2, KBusy, "gl_busy2", 8'h01);
        push(g + 2, KAct,  "gl_act2",  8'h00);
        push(g + 2, KIo,   "gl_io2",   8'h5A);
        tick();
        drv_en = 1'b0;
        push(g + 3, KBusy, "gl_busy3", 8'h00);
        push(g + 3, KAct,  "gl_act3",  8'h01);
        push(g + 3, KIo,   "gl_io3",   8'hC3);
        tick();
        push(g + 4, KBusy, "gl_busy4", 8'h01);
        push(g + 4, KAct,  "gl_act4",  8'h00);
        push(g + 4, KVal,  "gl_val4",  8'h00);
        tick();
        drv_en = 1'b1;
        push(g + 5, KBusy, "gl_busy5", 8'h01);
        push(g + 5, KAct,  "gl_act5",  8'h00);
        push(g + 5, KIo,   "gl_io5",   8'h5A);
        push(g + 5, KO,    "gl_loop",  8'hC3);
        push(g + 5, KVal,  "gl_val5",  8'h00);
        push(g + 6, KBusy, "gl_busy6", 8'h00);
        push(g + 6, KAct,  "gl_act6",  8'h00);
        push(g + 6, KIo,   "gl_io6",   8'h5A);
        push(g + 7, KVal,  "gl_val7",  8'h00);
        push(g + 8, KVal,  "gl_val8",  8'h01);
        push(g + 8, KO,    "gl_o8",    8'h5A);
        tick(); tick(); tick(); tick();

        foreach (sb[i]) begin
            n_chk++;
            $display("FAIL %s: got unchecked at edge %0d, want checked at edge %0d",
                     sb[i].tag, edge_n, sb[i].cyc);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
